// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus UART line signals for the fifo_uart_tx drain stage.
// master: the UART drain. slave: the FIFO / board side.
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (input fifo_empty, fifo_data, output fifo_rd, tx, busy, frame_done);
  modport slave  (output fifo_empty, fifo_data, input fifo_rd, tx, busy, frame_done);
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the 8-deep FIFO and shifts them out as 8N1 UART frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input logic             clock,
  input logic             reset,
  fifo_uart_tx_if.master  bus
);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LOAD, S_START, S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e        state_q;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q, rd_q, busy_q, done_q;
  logic          baud_wrap;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  assign baud_wrap = (baud_q == BAUD_LAST);
  assign baud_d    = baud_wrap ? '0 : baud_q + 1'b1;

  // tx is registered from the state, so the line lags the state by one
  // cycle; busy and frame_done are aligned to the line, not the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= !bus.fifo_empty;
          if (!bus.fifo_empty) begin
            state_q <= S_POP;
            rd_q    <= 1'b1;
          end
        end
        S_POP: state_q <= S_LOAD;
        S_LOAD: begin
          shift_q <= bus.fifo_data;
`ifdef UART_TX_PARITY_EN
          par_q   <= ^bus.fifo_data;
`endif
          baud_q  <= '0;
          bit_q   <= '0;
          state_q <= S_START;
        end
        S_START: begin
          tx_q   <= 1'b0;
          baud_q <= baud_d;
          if (baud_wrap) state_q <= S_DATA;
        end
        S_DATA: begin
          tx_q   <= shift_q[0];
          baud_q <= baud_d;
          if (baud_wrap) begin
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
            if (bit_q == 3'd7) state_q <= S_PARITY;
`else
            if (bit_q == 3'd7) state_q <= S_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          tx_q   <= par_q;
          baud_q <= baud_d;
          if (baud_wrap) state_q <= S_STOP;
        end
`endif
        S_STOP: begin
          tx_q   <= 1'b1;
          baud_q <= baud_d;
          if (baud_wrap) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.fifo_rd    = rd_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, per-cycle line log, frame-level reference.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int P    = NBITS * CPB + 3;
  localparam int LOGN = 4096;

  logic clock = 1'b0;
  logic reset;
  fifo_uart_tx_if bus();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  logic       tx_log [LOGN];
  logic       rd_log [LOGN];
  logic       bs_log [LOGN];
  logic       dn_log [LOGN];
  logic [7:0] fq [$];
  logic       rd_s;
  int         cyc, ncmp, nerr;

  task automatic chk(input string tag, input int cy, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cy, obs, exp);
    end
  endtask

  // One clock: FIFO pops on the edge that closes a fifo_rd cycle, outputs logged at negedge.
  task automatic cycle();
    @(posedge clock);
    cyc++;
    #1;
    if (rd_s && fq.size() > 0) bus.fifo_data = fq.pop_front();
    bus.fifo_empty = (fq.size() == 0);
    @(negedge clock);
    if (cyc < LOGN) begin
      tx_log[cyc] = bus.tx;
      rd_log[cyc] = bus.fifo_rd;
      bs_log[cyc] = bus.busy;
      dn_log[cyc] = bus.frame_done;
    end
    rd_s = bus.fifo_rd;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) cycle();
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    bus.fifo_empty = 1'b0;
  endtask

  // Line level r cycles after the fifo_rd cycle of a frame carrying b.
  function automatic logic exp_tx(input int r, input logic [7:0] b);
    int k;
    if (r < 3) return 1'b1;
    k = (r - 3) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Frames back to back from cycle e, then `tail` idle cycles.
  task automatic check_frames(input string tag, input int e, input logic [7:0] bytes[$], input int tail);
    int n, f, r, c;
    logic etx, erd, ebs, edn;
    n = bytes.size();
    for (int rel = 0; rel < n * P + tail; rel++) begin
      c = e + rel;
      f = rel / P;
      r = rel % P;
      if (f < n) begin
        etx = exp_tx(r, bytes[f]);
        erd = (r == 0);
        ebs = 1'b1;
        edn = (r == P - 1);
      end else begin
        etx = 1'b1; erd = 1'b0; ebs = 1'b0; edn = 1'b0;
      end
      if (c < LOGN) begin
        chk({tag, ".tx"},   c, tx_log[c], etx);
        chk({tag, ".rd"},   c, rd_log[c], erd);
        chk({tag, ".busy"}, c, bs_log[c], ebs);
        chk({tag, ".done"}, c, dn_log[c], edn);
      end
    end
  endtask

  initial begin
    int e, e2, k;
    logic [7:0] q[$];
    cyc = 0; ncmp = 0; nerr = 0; rd_s = 1'b0;
    reset = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = 8'h00;

    // reset values
    run_to(3);
    chk("rst.tx",   cyc, bus.tx,         1'b1);
    chk("rst.rd",   cyc, bus.fifo_rd,    1'b0);
    chk("rst.busy", cyc, bus.busy,       1'b0);
    chk("rst.done", cyc, bus.frame_done, 1'b0);

    // empty held: line stays idle, no pops
    reset = 1'b0;
    e = cyc + 1;
    run_to(e + 49);
    for (int c = e; c < e + 50; c++) begin
      chk("idle.tx",   c, tx_log[c], 1'b1);
      chk("idle.rd",   c, rd_log[c], 1'b0);
      chk("idle.busy", c, bs_log[c], 1'b0);
    end

    // single byte A5
    push(8'hA5);
    e = cyc + 1;
    run_to(e + P + 8);
    check_frames("a5", e, '{8'hA5}, 8);

    // preloaded burst: three frames, pops spaced by P
    push(8'h01); push(8'h80); push(8'hFF);
    e = cyc + 1;
    run_to(e + 3 * P + 8);
    check_frames("burst", e, '{8'h01, 8'h80, 8'hFF}, 8);

    // reset while shifting data bit 3; a new byte pops right after release
    push(8'h5A);
    e = cyc + 1;
    run_to(e + 18);
    for (int c = e; c <= e + 18; c++) chk("pre.tx", c, tx_log[c], exp_tx(c - e, 8'h5A));
    reset = 1'b1;
    cycle();
    chk("mid.tx",   cyc, bus.tx,         1'b1);
    chk("mid.busy", cyc, bus.busy,       1'b0);
    chk("mid.rd",   cyc, bus.fifo_rd,    1'b0);
    chk("mid.done", cyc, bus.frame_done, 1'b0);
    push(8'hC3);
    reset = 1'b0;
    e2 = cyc + 1;
    run_to(e2 + P + 8);
    check_frames("rel", e2, '{8'hC3}, 8);

    // FIFO empty throughout START: frame intact, no further pops
    push(8'h3C);
    e = cyc + 1;
    run_to(e + P + 20);
    check_frames("3c", e, '{8'h3C}, 20);

    // random pairs: second byte arrives at a random point mid-frame
    for (int it = 0; it < 4; it++) begin
      q.delete();
      q.push_back(8'($urandom()));
      q.push_back(8'($urandom()));
      push(q[0]);
      e = cyc + 1;
      k = $urandom_range(1, P);
      run_to(e - 1 + k);
      push(q[1]);
      run_to(e + 2 * P + 6);
      check_frames("rnd2", e, q, 6);
    end

    // random bursts of 1..4 preloaded bytes with random idle gaps
    for (int it = 0; it < 4; it++) begin
      q.delete();
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) begin
        q.push_back(8'($urandom()));
        push(q[j]);
      end
      e = cyc + 1;
      run_to(e + k * P + 6);
      check_frames("rndb", e, q, 6);
      run_to(cyc + $urandom_range(0, 5));
    end

`ifdef UART_TX_PARITY_EN
    push(8'h07);
    e = cyc + 1;
    run_to(e + P + 4);
    chk("par07", e + 3 + 9 * CPB, tx_log[e + 3 + 9 * CPB], 1'b1);
    check_frames("p07", e, '{8'h07}, 4);
    push(8'h03);
    e = cyc + 1;
    run_to(e + P + 4);
    chk("par03", e + 3 + 9 * CPB, tx_log[e + 3 + 9 * CPB], 1'b0);
    check_frames("p03", e, '{8'h03}, 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial drain stage placed directly downstream of the 8-deep byte FIFO on the Basys3 build. Pops one byte at a time from the FIFO read port, then shifts it out on the board's USB-UART TX pin as 8N1 (optionally 8E1) frames at a fixed baud. Holds the FIFO read strobe low while a frame is in flight, so the FIFO absorbs bursts from the upstream writer.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 2
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- fifo_empty  in  1  FIFO empty flag (combinational in FIFO)
- fifo_data  in  8  FIFO registered read data (DATAOUT)
- fifo_rd  out  1  FIFO read request (rn), one-cycle pulse per byte
- tx  out  1  UART serial line, idle high
- busy  out  1  high from POP through last stop-bit cycle
- frame_done  out  1  one-cycle pulse in last cycle of stop bit

## Operation
- States: IDLE, POP, LOAD, START, DATA, PARITY (macro only), STOP.
- IDLE: tx=1. If fifo_empty=0 at an edge, go to POP. Otherwise stay.
- POP: fifo_rd=1 for exactly this cycle. The FIFO updates DATAOUT at the closing edge. Unconditionally go to LOAD.
- LOAD: fifo_data is valid. Capture it into 8-bit shift_reg at the closing edge. Clear baud_cnt and bit_idx. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx=shift_reg[0], sent LSB first. When baud_cnt reaches CLKS_PER_BIT-1:
  - shift right and increment bit_idx;
  - after bit 7, go to PARITY (macro defined) or STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 in the final cycle. Then go to IDLE.
- fifo_rd is a decode of the registered state (POP only). It is never asserted outside POP, never while busy on a frame, and never when fifo_empty was 1 at the IDLE decision edge.
- baud_cnt width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. bit_idx is 3 bits.
- The FIFO gives write priority over read. Integration rule: the upstream writer never asserts wn in the cycle fifo_rd=1. This block performs no read-back check.
- fifo_empty is ignored in every state except IDLE. A FIFO going empty mid-frame does not affect the frame in flight.
- Reset mid-frame: at the reset edge, state=IDLE, tx=1, fifo_rd=0, busy=0, frame_done=0, and counters clear. The truncated frame is abandoned and the popped byte is lost.

## Timing
- Reset values: tx=1, fifo_rd=0, busy=0, frame_done=0, state=IDLE.
- Edge E0: IDLE samples fifo_empty=0.
- Cycle after E0: fifo_rd=1 and busy=1.
- Cycle after E0+1: LOAD, with fifo_data valid.
- Edge E0+3: tx falls (start bit).
- Frame length from START to end of STOP: 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
- Back-to-back frames: after STOP, one IDLE cycle, then POP, then LOAD. Inter-frame gap is 3 cycles of tx=1 beyond the stop bit.
- Pop rate is at most one per frame. The FIFO never sees two fifo_rd pulses closer than 10*CLKS_PER_BIT+3 cycles.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP.
  - tx = even parity (XOR of the captured byte) for CLKS_PER_BIT cycles.
  - Parity is computed from the byte latched in LOAD, not the shifted register.
- UART_TX_PARITY_EN undefined: PARITY state and parity logic absent. DATA goes directly to STOP, giving 8N1.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset, fifo_empty=1 held for 50 cycles -> tx=1, fifo_rd never asserted, busy=0.
- Single byte 8'hA5, empty falls at edge E0:
  - fifo_rd high only in cycle E0+1; tx falls at E0+3;
  - tx bits 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles;
  - frame_done pulses once; the frame is 40 cycles.
- FIFO preloaded with 8'h01, 8'h80, 8'hFF:
  - three frames decoded in order;
  - exactly three fifo_rd pulses, spaced 43 cycles;
  - busy drops only after the third stop bit.
- Reset asserted in DATA at bit 3 -> next edge gives tx=1, busy=0, IDLE. With empty=0 afterwards, a fresh POP follows one cycle after reset deasserts.
- Empty goes high during START of a frame for 8'h3C -> frame completes intact, and no further fifo_rd is issued.
- With UART_TX_PARITY_EN defined, send 8'h07 -> parity bit 1, frame is 44 cycles. Send 8'h03 -> parity bit 0.
